// File: rtl/fsm_sw_pkg.sv
// rtl/fsm_sw_pkg.sv - shared types and next-state helper for the switch-driven FSM
package fsm_sw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        S3   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_FWD  = 2'b01,
        CMD_BACK = 2'b10,
        CMD_HOME = 2'b11
    } cmd_t;

    // Forward and backward walks saturate at the ends instead of wrapping.
    function automatic state_t fsm_next(input state_t cur, input cmd_t cmd);
        state_t nxt;
        nxt = cur;
        case (cmd)
            CMD_HOLD: nxt = cur;
            CMD_FWD: begin
                case (cur)
                    IDLE:    nxt = S1;
                    S1:      nxt = S2;
                    S2:      nxt = S3;
                    S3:      nxt = S3;
                    default: nxt = IDLE;
                endcase
            end
            CMD_BACK: begin
                case (cur)
                    IDLE:    nxt = IDLE;
                    S1:      nxt = IDLE;
                    S2:      nxt = S1;
                    S3:      nxt = S2;
                    default: nxt = IDLE;
                endcase
            end
            CMD_HOME: nxt = IDLE;
            default:  nxt = IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sw_sync.sv
// rtl/sw_sync.sv - multi-stage flop synchronizer for asynchronous inputs
module sw_sync #(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/fsm_sw_top.sv
// rtl/fsm_sw_top.sv - switch-stepped 4-state Moore FSM with registered status LEDs
module fsm_sw_top
    import fsm_sw_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sw,
    output logic       track_states,
    output logic       track_reset
);

    logic [1:0] s;
    state_t     state;
    state_t     next_state;

    // rst_n is active-high despite its name.
    sw_sync #(
        .WIDTH  (2),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .clk (clk),
        .rst (rst_n),
        .d   (sw),
        .q   (s)
    );

    always_comb begin
        next_state = fsm_next(state, cmd_t'(s));
    end

    // Both LEDs are computed from next_state so they line up with the new state.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state        <= IDLE;
            track_states <= 1'b0;
            track_reset  <= 1'b1;
        end else begin
            state        <= next_state;
            track_states <= (next_state != state);
            track_reset  <= (next_state == IDLE);
        end
    end

endmodule

// File: tb/tb_fsm_sw_top.sv
// tb/tb_fsm_sw_top.sv - scoreboard bench for the switch-stepped FSM
module tb_fsm_sw_top;
    import fsm_sw_pkg::*;

    typedef struct packed {
        logic [1:0] st;
        logic       ts;
        logic       tr;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] sw;
    logic       track_states;
    logic       track_reset;

    exp_t exp_q[$];
    exp_t e_mon;
    int   checks;
    int   failures;

    logic [1:0] m_s0, m_s1, m_st;
    logic       m_ts, m_tr;

    fsm_sw_top #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .track_states (track_states),
        .track_reset  (track_reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_next(input logic [1:0] st, input logic [1:0] cmd);
        case (cmd)
            2'b00:   return st;
            2'b01:   return (st == 2'd3) ? 2'd3 : st + 2'd1;
            2'b10:   return (st == 2'd0) ? 2'd0 : st - 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    // Drive one cycle of inputs and enqueue the outputs expected after the next edge.
    task automatic step(input logic [1:0] x, input logic r, input logic [1:0] es,
                        input logic ets, input logic etr, input bit use_model);
        logic [1:0] nxt;
        exp_t e;
        @(negedge clk);
        sw    = x;
        rst_n = r;
        if (r) begin
            m_s0 = 2'b00; m_s1 = 2'b00; m_st = 2'd0; m_ts = 1'b0; m_tr = 1'b1;
        end else begin
            nxt  = model_next(m_st, m_s1);
            m_ts = (nxt != m_st);
            m_tr = (nxt == 2'd0);
            m_st = nxt;
            m_s1 = m_s0;
            m_s0 = x;
        end
        if (use_model) begin
            e.st = m_st; e.ts = m_ts; e.tr = m_tr;
        end else begin
            e.st = es; e.ts = ets; e.tr = etr;
        end
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            chk("state", dut.state, e_mon.st);
            chk("track_states", {1'b0, track_states}, {1'b0, e_mon.ts});
            chk("track_reset", {1'b0, track_reset}, {1'b0, e_mon.tr});
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        sw       = 2'b01;
        m_s0 = 2'b00; m_s1 = 2'b00; m_st = 2'd0; m_ts = 1'b0; m_tr = 1'b1;

        // reset held with sw=01, then released with sw=00
        step(2'b01, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b01, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

        // forward walk, two-edge latency then saturation in S3
        step(2'b01, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b01, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b01, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);

        // backward walk to IDLE and saturation there
        step(2'b10, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        step(2'b10, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
        step(2'b10, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
        step(2'b10, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
        step(2'b10, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        step(2'b10, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

        // climb to S2, single-cycle home, then home held in IDLE
        step(2'b01, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b01, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b00, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
        step(2'b00, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
        step(2'b11, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        step(2'b11, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b11, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b11, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b11, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

        // reset lands on the edge that would move S1 to S2
        step(2'b01, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b01, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b01, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
        step(2'b01, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b01, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b01, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b01, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
        step(2'b11, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
        step(2'b11, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
        step(2'b00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        step(2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

        // random: two sw changes per cycle, the mid-high one is a lost glitch
        for (int i = 0; i < 30; i++) begin
            step(2'($urandom_range(0, 3)), 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
            @(posedge clk);
            #3;
            sw = 2'($urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 pending expectations", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
